// File: rtl/csr_pkg.sv
// -----------------------------------------------------------------------------
// csr_pkg
// Shared constants for the machine-mode CSR file and trap controller:
//   - CSR addresses of every implemented register
//   - mstatus / mip bit positions
//   - exception and interrupt cause codes
//   - csr_op_e: the CSR operation decoded from funct3[1:0]
// -----------------------------------------------------------------------------
package csr_pkg;

    // SYSTEM major opcode carrying CSR instructions and MRET
    localparam logic [6:0]  OPCODE_SYSTEM = 7'b1110011;

    // Implemented CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    // RV32I, MXL=1
    localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;

    // mstatus bit positions
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MSTATUS_MPP0 = 11;
    localparam int MSTATUS_MPP1 = 12;

    // Interrupt cause codes, which are also their mip/mie bit positions
    localparam logic [4:0] IRQ_MSI        = 5'd3;
    localparam logic [4:0] IRQ_MTI        = 5'd7;
    localparam logic [4:0] IRQ_MEI        = 5'd11;
    localparam int         IRQ_LOCAL_BASE = 16;

    // Exception cause codes
    localparam logic [4:0] EXC_ILLEGAL    = 5'd2;

    // Decoded from funct3[1:0]; 00 is not a CSR instruction (ECALL/MRET/...)
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

endpackage

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Combinational priority encoder for enabled, pending machine interrupts.
// Order: MEI(11) > MSI(3) > MTI(7) > local lines (bit 16 upward, lowest first).
// Ports:
//   i_pending  in  32  mip & mie & {32{mstatus.MIE}}
//   o_valid    out 1   at least one interrupt pending
//   o_cause    out 5   cause code of the winning interrupt
// -----------------------------------------------------------------------------
module irq_prio_enc
    import csr_pkg::*;
(
    input  logic [31:0] i_pending,
    output logic        o_valid,
    output logic [4:0]  o_cause
);

    // Later assignments override earlier ones, so the scan goes from the
    // lowest priority source up to the highest.
    always_comb begin
        o_valid = |i_pending;
        o_cause = '0;
        for (int i = 31; i >= IRQ_LOCAL_BASE; i--) begin
            if (i_pending[i]) begin
                o_cause = 5'(i);
            end
        end
        if (i_pending[IRQ_MTI]) o_cause = IRQ_MTI;
        if (i_pending[IRQ_MSI]) o_cause = IRQ_MSI;
        if (i_pending[IRQ_MEI]) o_cause = IRQ_MEI;
    end

endmodule

// File: rtl/csr_trap_unit.sv
// -----------------------------------------------------------------------------
// csr_trap_unit
// Machine-mode CSR file and trap controller beside the execute stage.
// Decodes CSRRW/S/C(I), keeps mstatus/mie/mtvec/mscratch/mepc/mcause/mtval and
// 64-bit mcycle/minstret, arbitrates exceptions against prioritised interrupts
// and emits a one-cycle redirect to fetch for traps and MRET.
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   instr_i, instr_valid_i         execute-stage instruction and its valid
//   rs1_data_i                     rs1 operand for register CSR forms
//   pc_i                           PC of the execute-stage instruction
//   exc_valid_i/exc_cause_i/
//   exc_tval_i                     synchronous exception on that instruction
//   mret_i                         MRET executing (qualified by instr_valid_i)
//   retire_i                       instruction retired this cycle
//   irq_ext_i/irq_timer_i/
//   irq_soft_i/irq_local_i         level-sensitive interrupt requests
//   rdata_o                        CSR read data (old value, combinational)
//   illegal_o                      unimplemented CSR or write to read-only CSR
//   redirect_o/redirect_pc_o       one-cycle fetch redirect and its target
//   epc_o                          current mepc
//
// Sideband contract: there is no handshake. An event is accepted on the edge
// that closes any cycle where instr_valid_i is high; redirect_o is valid for
// exactly that cycle and fetch must act on it without back-pressure.
// -----------------------------------------------------------------------------
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter int          NUM_LOCAL_IRQ = 16,
    parameter logic [31:0] MTVEC_RESET   = 32'h0000_0100,
    parameter bit          HAS_COUNTERS  = 1'b1
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              instr_i,
    input  logic                     instr_valid_i,
    input  logic [31:0]              rs1_data_i,
    input  logic [31:0]              pc_i,
    input  logic                     exc_valid_i,
    input  logic [4:0]               exc_cause_i,
    input  logic [31:0]              exc_tval_i,
    input  logic                     mret_i,
    input  logic                     retire_i,
    input  logic                     irq_ext_i,
    input  logic                     irq_timer_i,
    input  logic                     irq_soft_i,
    input  logic [NUM_LOCAL_IRQ-1:0] irq_local_i,
    output logic [31:0]              rdata_o,
    output logic                     illegal_o,
    output logic                     redirect_o,
    output logic [31:0]              redirect_pc_o,
    output logic [31:0]              epc_o
);

    // Writable mie bits: the three standard sources plus the local lines
    localparam logic [31:0] LOCAL_IRQ_MASK =
        ((32'h1 << NUM_LOCAL_IRQ) - 32'h1) << IRQ_LOCAL_BASE;
    localparam logic [31:0] MIE_WMASK = LOCAL_IRQ_MASK | 32'h0000_0888;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rs1_field;
    logic [11:0] w_addr;
    csr_op_e     w_csr_op;
    logic        w_is_csr;
    logic        w_wr_attempt;
    logic [31:0] w_src;
    logic        w_unused;

    assign w_opcode    = instr_i[6:0];
    assign w_funct3    = instr_i[14:12];
    assign w_rs1_field = instr_i[19:15];
    assign w_addr      = instr_i[31:20];
    // rd is written back by the pipeline, not here
    assign w_unused    = &{1'b0, instr_i[11:7]};

    always_comb begin
        w_csr_op = CSR_OP_NONE;
        if (w_opcode == OPCODE_SYSTEM) begin
            w_csr_op = csr_op_e'(w_funct3[1:0]);
        end
    end

    assign w_is_csr = (w_csr_op != CSR_OP_NONE);
    // funct3[2] selects the zero-extended immediate forms
    assign w_src    = w_funct3[2] ? {27'b0, w_rs1_field} : rs1_data_i;
    // RS/RC with a zero rs1 field are pure reads with no side effects
    assign w_wr_attempt = w_is_csr &&
                          ((w_csr_op == CSR_OP_RW) || (w_rs1_field != 5'd0));

    // ------------------------------------------------------------------
    // Read view of the CSRs
    // ------------------------------------------------------------------
    logic [31:0] w_mip;
    logic [31:0] w_mstatus;
    logic [31:0] w_rdata;
    logic        w_known;

    always_comb begin
        w_mip                 = '0;
        w_mip[IRQ_MSI]        = irq_soft_i;
        w_mip[IRQ_MTI]        = irq_timer_i;
        w_mip[IRQ_MEI]        = irq_ext_i;
        w_mip[IRQ_LOCAL_BASE +: NUM_LOCAL_IRQ] = irq_local_i;
    end

    // MPP is hardwired to machine mode, so it always reads 2'b11
    always_comb begin
        w_mstatus               = '0;
        w_mstatus[MSTATUS_MIE]  = r_mstatus_mie;
        w_mstatus[MSTATUS_MPIE] = r_mstatus_mpie;
        w_mstatus[MSTATUS_MPP0] = 1'b1;
        w_mstatus[MSTATUS_MPP1] = 1'b1;
    end

    always_comb begin
        w_rdata = '0;
        w_known = 1'b1;
        case (w_addr)
            CSR_MSTATUS:   w_rdata = w_mstatus;
            CSR_MISA:      w_rdata = MISA_VALUE;
            CSR_MIE:       w_rdata = r_mie;
            CSR_MTVEC:     w_rdata = r_mtvec;
            CSR_MSCRATCH:  w_rdata = r_mscratch;
            CSR_MEPC:      w_rdata = r_mepc;
            CSR_MCAUSE:    w_rdata = r_mcause;
            CSR_MTVAL:     w_rdata = r_mtval;
            CSR_MIP:       w_rdata = w_mip;
            CSR_MCYCLE:    w_rdata = r_mcycle[31:0];
            CSR_MCYCLEH:   w_rdata = r_mcycle[63:32];
            CSR_MINSTRET:  w_rdata = r_minstret[31:0];
            CSR_MINSTRETH: w_rdata = r_minstret[63:32];
            default:       w_known = 1'b0;
        endcase
    end

    // Write data is computed from the old value seen on rdata
    logic [31:0] w_wdata;
    always_comb begin
        w_wdata = w_rdata;
        case (w_csr_op)
            CSR_OP_RW: w_wdata = w_src;
            CSR_OP_RS: w_wdata = w_rdata | w_src;
            CSR_OP_RC: w_wdata = w_rdata & ~w_src;
            default:   w_wdata = w_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Trap arbitration
    // ------------------------------------------------------------------
    logic        w_illegal;
    logic [31:0] w_pending;
    logic        w_irq_valid;
    logic [4:0]  w_irq_cause;
    logic        w_exc;
    logic        w_trap;
    logic [4:0]  w_trap_cause;
    logic        w_mret;
    logic        w_csr_we;
    logic [31:0] w_mtvec_base;
    logic [31:0] w_trap_pc;

    assign w_illegal = instr_valid_i && w_is_csr &&
                       (!w_known || (w_wr_attempt && (w_addr == CSR_MISA)));

    assign w_pending = w_mip & r_mie & {32{r_mstatus_mie}};

    irq_prio_enc u_irq_prio_enc (
        .i_pending (w_pending),
        .o_valid   (w_irq_valid),
        .o_cause   (w_irq_cause)
    );

    // Exceptions (including illegal CSR access) always beat interrupts
    assign w_exc  = exc_valid_i || w_illegal;
    assign w_trap = instr_valid_i && (w_exc || w_irq_valid);

    always_comb begin
        w_trap_cause = w_irq_cause;
        if (exc_valid_i) begin
            w_trap_cause = exc_cause_i;
        end else if (w_illegal) begin
            w_trap_cause = EXC_ILLEGAL;
        end
    end

    // A trap in the same cycle kills the MRET, the CSR write and the retire
    assign w_mret   = instr_valid_i && mret_i && !w_trap;
    assign w_csr_we = instr_valid_i && w_wr_attempt && !w_trap;

    // Vectored mode only offsets interrupts; exceptions go to the base
    assign w_mtvec_base = {r_mtvec[31:2], 2'b00};
    assign w_trap_pc    = (r_mtvec[0] && !w_exc)
                        ? (w_mtvec_base + {25'b0, w_trap_cause, 2'b00})
                        : w_mtvec_base;

    // ------------------------------------------------------------------
    // Outputs (held quiet while reset is asserted)
    // ------------------------------------------------------------------
    always_comb begin
        redirect_pc_o = '0;
        if (w_trap) begin
            redirect_pc_o = w_trap_pc;
        end else if (w_mret) begin
            redirect_pc_o = r_mepc;
        end
        if (!rst) begin
            redirect_pc_o = '0;
        end
    end

    assign rdata_o    = w_rdata;
    assign illegal_o  = rst && w_illegal;
    assign redirect_o = rst && (w_trap || w_mret);
    assign epc_o      = r_mepc;

    // ------------------------------------------------------------------
    // mstatus: trap > CSR write > MRET
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
        end else if (w_trap) begin
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (w_csr_we && (w_addr == CSR_MSTATUS)) begin
            r_mstatus_mie  <= w_wdata[MSTATUS_MIE];
            r_mstatus_mpie <= w_wdata[MSTATUS_MPIE];
        end else if (w_mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Plain software-written CSRs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mie      <= '0;
            r_mtvec    <= MTVEC_RESET & ~32'h2;
            r_mscratch <= '0;
        end else if (w_csr_we) begin
            if (w_addr == CSR_MIE)      r_mie      <= w_wdata & MIE_WMASK;
            if (w_addr == CSR_MTVEC)    r_mtvec    <= w_wdata & ~32'h2;
            if (w_addr == CSR_MSCRATCH) r_mscratch <= w_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Trap-state CSRs: a trap captures them, otherwise software may write
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mepc   <= '0;
            r_mcause <= '0;
            r_mtval  <= '0;
        end else if (w_trap) begin
            r_mepc   <= {pc_i[31:2], 2'b00};
            r_mcause <= {!w_exc, 26'b0, w_trap_cause};
            r_mtval  <= w_exc ? exc_tval_i : 32'h0;
        end else if (w_csr_we) begin
            if (w_addr == CSR_MEPC)   r_mepc   <= {w_wdata[31:2], 2'b00};
            if (w_addr == CSR_MCAUSE) r_mcause <= w_wdata;
            if (w_addr == CSR_MTVAL)  r_mtval  <= w_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Counters: a write to either half replaces that cycle's increment.
    // Without HAS_COUNTERS they stay at their reset value of zero.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else if (HAS_COUNTERS) begin
            if (w_csr_we && (w_addr == CSR_MCYCLE)) begin
                r_mcycle <= {r_mcycle[63:32], w_wdata};
            end else if (w_csr_we && (w_addr == CSR_MCYCLEH)) begin
                r_mcycle <= {w_wdata, r_mcycle[31:0]};
            end else begin
                r_mcycle <= r_mcycle + 64'd1;
            end

            if (w_csr_we && (w_addr == CSR_MINSTRET)) begin
                r_minstret <= {r_minstret[63:32], w_wdata};
            end else if (w_csr_we && (w_addr == CSR_MINSTRETH)) begin
                r_minstret <= {w_wdata, r_minstret[31:0]};
            end else if (retire_i && !w_trap) begin
                r_minstret <= r_minstret + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_csr_trap_unit.sv
// -----------------------------------------------------------------------------
// tb_csr_trap_unit
// Directed bench: a table of single-cycle vectors for CSR access, illegal
// access and MRET, followed by hand-written sequences for interrupts,
// exception/interrupt collision, counter wrap, retire suppression and reset.
// -----------------------------------------------------------------------------
module tb_csr_trap_unit;
    import csr_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] instr_i;
    logic        instr_valid_i;
    logic [31:0] rs1_data_i;
    logic [31:0] pc_i;
    logic        exc_valid_i;
    logic [4:0]  exc_cause_i;
    logic [31:0] exc_tval_i;
    logic        mret_i;
    logic        retire_i;
    logic        irq_ext_i;
    logic        irq_timer_i;
    logic        irq_soft_i;
    logic [15:0] irq_local_i;
    logic [31:0] rdata_o;
    logic        illegal_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic [31:0] epc_o;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] MRET = 32'h3020_0073;

    csr_trap_unit #(
        .NUM_LOCAL_IRQ (16),
        .MTVEC_RESET   (32'h0000_0100),
        .HAS_COUNTERS  (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .rs1_data_i    (rs1_data_i),
        .pc_i          (pc_i),
        .exc_valid_i   (exc_valid_i),
        .exc_cause_i   (exc_cause_i),
        .exc_tval_i    (exc_tval_i),
        .mret_i        (mret_i),
        .retire_i      (retire_i),
        .irq_ext_i     (irq_ext_i),
        .irq_timer_i   (irq_timer_i),
        .irq_soft_i    (irq_soft_i),
        .irq_local_i   (irq_local_i),
        .rdata_o       (rdata_o),
        .illegal_o     (illegal_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .epc_o         (epc_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [31:0] enc(input logic [2:0] f3, input logic [11:0] addr,
                                        input logic [4:0] rs1f);
        return {addr, rs1f, f3, 5'd1, OPCODE_SYSTEM};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive inputs just after the rising edge; sample 4 ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        instr_i       = NOP;
        instr_valid_i = 1'b0;
        rs1_data_i    = '0;
        pc_i          = '0;
        exc_valid_i   = 1'b0;
        exc_cause_i   = '0;
        exc_tval_i    = '0;
        mret_i        = 1'b0;
        retire_i      = 1'b0;
    endtask

    // Side-effect-free read: instr_valid_i low, rdata is combinational
    task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
        idle();
        instr_i = enc(3'b010, addr, 5'd0);
        #4;
        chk(name, rdata_o, exp);
        step();
    endtask

    // Valid instruction, checks the redirect outcome of that cycle
    task automatic exec(input string name, input logic [31:0] ins, input logic [31:0] rs1,
                        input logic [31:0] pc, input logic exp_redir,
                        input logic [31:0] exp_pc);
        instr_i       = ins;
        rs1_data_i    = rs1;
        pc_i          = pc;
        instr_valid_i = 1'b1;
        #4;
        chk({name, ".redirect"}, {31'b0, redirect_o}, {31'b0, exp_redir});
        if (exp_redir) chk({name, ".redirect_pc"}, redirect_pc_o, exp_pc);
        step();
        idle();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        valid;
        logic        mret;
        logic [31:0] rs1;
        logic [31:0] pc;
        logic [31:0] exp_rdata;
        logic        exp_ill;
        logic        exp_redir;
        logic [31:0] exp_rpc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic [31:0] ins, input logic v,
                                input logic m, input logic [31:0] rs, input logic [31:0] p,
                                input logic [31:0] er, input logic ei, input logic ed,
                                input logic [31:0] ep);
        vec_t t;
        t.name = n; t.instr = ins; t.valid = v; t.mret = m; t.rs1 = rs; t.pc = p;
        t.exp_rdata = er; t.exp_ill = ei; t.exp_redir = ed; t.exp_rpc = ep;
        return t;
    endfunction

    initial begin
        // ---------- reset ----------
        rst         = 1'b0;
        irq_ext_i   = 1'b0;
        irq_timer_i = 1'b0;
        irq_soft_i  = 1'b0;
        irq_local_i = '0;
        idle();
        step();
        step();
        // An excepting instruction during reset must not redirect
        instr_i       = enc(3'b010, CSR_MTVEC, 5'd0);
        instr_valid_i = 1'b1;
        exc_valid_i   = 1'b1;
        #2;
        chk("rst.redirect", {31'b0, redirect_o}, 32'h0);
        chk("rst.mtvec", rdata_o, 32'h0000_0100);
        chk("rst.epc", epc_o, 32'h0);
        step();
        idle();
        rst = 1'b1;

        // ---------- table ----------
        //             name           instr                              v   m   rs1           pc          rdata         ill red rpc
        vecs.push_back(mk("rst_mtvec",  enc(3'b010, CSR_MTVEC, 0),     1, 0, 0,            0,          32'h100,      0, 0, 0));
        vecs.push_back(mk("rst_misa",   enc(3'b010, CSR_MISA, 0),      1, 0, 0,            0,          32'h40000100, 0, 0, 0));
        vecs.push_back(mk("rst_mstat",  enc(3'b010, CSR_MSTATUS, 0),   1, 0, 0,            0,          32'h1800,     0, 0, 0));
        vecs.push_back(mk("rst_mepc",   enc(3'b010, CSR_MEPC, 0),      1, 0, 0,            0,          32'h0,        0, 0, 0));
        vecs.push_back(mk("misa_wr",    enc(3'b001, CSR_MISA, 5),      1, 0, 0,            32'h40,     32'h40000100, 1, 1, 32'h100));
        vecs.push_back(mk("mcause_ill", enc(3'b010, CSR_MCAUSE, 0),    1, 0, 0,            0,          32'h2,        0, 0, 0));
        vecs.push_back(mk("mepc_ill",   enc(3'b010, CSR_MEPC, 0),      1, 0, 0,            0,          32'h40,       0, 0, 0));
        vecs.push_back(mk("unimpl",     enc(3'b010, 12'h7C0, 0),       1, 0, 0,            32'h80,     32'h0,        1, 1, 32'h100));
        vecs.push_back(mk("scr_rw",     enc(3'b001, CSR_MSCRATCH, 5),  1, 0, 32'hA5A50F0F, 0,          32'h0,        0, 0, 0));
        vecs.push_back(mk("scr_rs",     enc(3'b010, CSR_MSCRATCH, 5),  1, 0, 32'h0000F0F0, 0,          32'hA5A50F0F, 0, 0, 0));
        vecs.push_back(mk("scr_rc",     enc(3'b011, CSR_MSCRATCH, 5),  1, 0, 32'hA5A50000, 0,          32'hA5A5FFFF, 0, 0, 0));
        vecs.push_back(mk("scr_rsi0",   enc(3'b110, CSR_MSCRATCH, 0),  1, 0, 32'hFFFFFFFF, 0,          32'h0000FFFF, 0, 0, 0));
        vecs.push_back(mk("scr_rci",    enc(3'b111, CSR_MSCRATCH, 31), 1, 0, 0,            0,          32'h0000FFFF, 0, 0, 0));
        vecs.push_back(mk("scr_rd",     enc(3'b010, CSR_MSCRATCH, 0),  1, 0, 0,            0,          32'h0000FFE0, 0, 0, 0));
        vecs.push_back(mk("mtvec_w",    enc(3'b001, CSR_MTVEC, 5),     1, 0, 32'h203,      0,          32'h100,      0, 0, 0));
        vecs.push_back(mk("mtvec_rd",   enc(3'b010, CSR_MTVEC, 0),     1, 0, 0,            0,          32'h201,      0, 0, 0));
        vecs.push_back(mk("mepc_w",     enc(3'b001, CSR_MEPC, 5),      1, 0, 32'h1237,     0,          32'h80,       0, 0, 0));
        vecs.push_back(mk("mepc_rd",    enc(3'b010, CSR_MEPC, 0),      1, 0, 0,            0,          32'h1234,     0, 0, 0));
        vecs.push_back(mk("mip_w",      enc(3'b001, CSR_MIP, 5),       1, 0, 32'hFFFFFFFF, 0,          32'h0,        0, 0, 0));
        vecs.push_back(mk("mip_rd",     enc(3'b010, CSR_MIP, 0),       1, 0, 0,            0,          32'h0,        0, 0, 0));
        vecs.push_back(mk("mstat_w",    enc(3'b001, CSR_MSTATUS, 5),   1, 0, 32'h80,       0,          32'h1800,     0, 0, 0));
        vecs.push_back(mk("mstat_rs0",  enc(3'b010, CSR_MSTATUS, 0),   1, 0, 32'hFFFFFFFF, 0,          32'h1880,     0, 0, 0));
        vecs.push_back(mk("mstat_rd",   enc(3'b010, CSR_MSTATUS, 0),   1, 0, 0,            0,          32'h1880,     0, 0, 0));
        vecs.push_back(mk("mret_nv",    MRET,                          0, 1, 0,            0,          32'h0,        0, 0, 0));
        vecs.push_back(mk("mret",       MRET,                          1, 1, 0,            0,          32'h0,        0, 1, 32'h1234));
        vecs.push_back(mk("mstat_mret", enc(3'b010, CSR_MSTATUS, 0),   1, 0, 0,            0,          32'h1888,     0, 0, 0));

        foreach (vecs[i]) begin
            idle();
            instr_i       = vecs[i].instr;
            instr_valid_i = vecs[i].valid;
            mret_i        = vecs[i].mret;
            rs1_data_i    = vecs[i].rs1;
            pc_i          = vecs[i].pc;
            #4;
            chk({vecs[i].name, ".rdata"}, rdata_o, vecs[i].exp_rdata);
            chk({vecs[i].name, ".illegal"}, {31'b0, illegal_o}, {31'b0, vecs[i].exp_ill});
            chk({vecs[i].name, ".redirect"}, {31'b0, redirect_o}, {31'b0, vecs[i].exp_redir});
            if (vecs[i].exp_redir) begin
                chk({vecs[i].name, ".redirect_pc"}, redirect_pc_o, vecs[i].exp_rpc);
            end
            step();
        end
        idle();

        // ---------- timer interrupt, vectored mtvec=0x201, MIE=1 ----------
        exec("mie_mti", enc(3'b001, CSR_MIE, 5), 32'h80, 0, 1'b0, 0);
        irq_timer_i = 1'b1;
        exec("mti_take", NOP, 0, 32'h300, 1'b1, 32'h21C);
        rd("mti.mcause", CSR_MCAUSE, 32'h8000_0007);
        rd("mti.mstatus", CSR_MSTATUS, 32'h1880);
        rd("mti.mepc", CSR_MEPC, 32'h300);
        rd("mti.mtval", CSR_MTVAL, 32'h0);
        irq_timer_i = 1'b0;

        // ---------- exception together with an enabled external irq ----------
        mret_i = 1'b1;
        exec("mret1", MRET, 0, 0, 1'b1, 32'h300);
        exec("mie_mei", enc(3'b001, CSR_MIE, 5), 32'h800, 0, 1'b0, 0);
        irq_ext_i   = 1'b1;
        exc_valid_i = 1'b1;
        exc_cause_i = 5'd2;
        exc_tval_i  = 32'hDEAD_BEEF;
        exec("exc_irq", enc(3'b001, CSR_MSCRATCH, 5), 32'h1234_5678, 32'h400, 1'b1, 32'h200);
        irq_ext_i = 1'b0;
        rd("exc.mcause", CSR_MCAUSE, 32'h2);
        rd("exc.mtval", CSR_MTVAL, 32'hDEAD_BEEF);
        rd("exc.mscratch", CSR_MSCRATCH, 32'h0000_FFE0);
        chk("exc.epc_o", epc_o, 32'h400);

        // ---------- two local lines pending: lowest index wins ----------
        mret_i = 1'b1;
        exec("mret2", MRET, 0, 0, 1'b1, 32'h400);
        exec("mie_loc", enc(3'b001, CSR_MIE, 5), 32'h0009_0000, 0, 1'b0, 0);
        irq_local_i = 16'h0009;
        exec("loc_take", NOP, 0, 32'h500, 1'b1, 32'h240);
        irq_local_i = '0;
        rd("loc.mcause", CSR_MCAUSE, 32'h8000_0010);

        // ---------- mcycle carry into mcycleh ----------
        exec("mcycleh_w", enc(3'b001, CSR_MCYCLEH, 5), 32'h0, 0, 1'b0, 0);
        exec("mcycle_w", enc(3'b001, CSR_MCYCLE, 5), 32'hFFFF_FFFF, 0, 1'b0, 0);
        rd("wrap.mcycle_pre", CSR_MCYCLE, 32'hFFFF_FFFF);
        rd("wrap.mcycle", CSR_MCYCLE, 32'h0);
        rd("wrap.mcycleh", CSR_MCYCLEH, 32'h1);

        // ---------- minstret: retire counts, trap suppresses it ----------
        exec("minstret_w", enc(3'b001, CSR_MINSTRET, 5), 32'h5, 0, 1'b0, 0);
        retire_i = 1'b1;
        exec("retire", NOP, 0, 32'h600, 1'b0, 0);
        retire_i    = 1'b1;
        exc_valid_i = 1'b1;
        exec("retire_trap", NOP, 0, 32'h604, 1'b1, 32'h200);
        rd("minstret", CSR_MINSTRET, 32'h6);
        rd("minstreth", CSR_MINSTRETH, 32'h0);

        // ---------- reset in the middle of a cycle ----------
        instr_i       = enc(3'b010, CSR_MTVEC, 5'd0);
        instr_valid_i = 1'b1;
        exc_valid_i   = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst.redirect", {31'b0, redirect_o}, 32'h0);
        chk("mid_rst.mtvec", rdata_o, 32'h100);
        step();
        idle();
        rst = 1'b1;
        rd("mid_rst.mscratch", CSR_MSCRATCH, 32'h0);
        rd("mid_rst.mstatus", CSR_MSTATUS, 32'h1800);
        rd("mid_rst.mcause", CSR_MCAUSE, 32'h0);
        rd("mid_rst.mie", CSR_MIE, 32'h0);
        rd("mid_rst.mepc", CSR_MEPC, 32'h0);
        rd("mid_rst.mcycleh", CSR_MCYCLEH, 32'h0);
        rd("mid_rst.minstret", CSR_MINSTRET, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
